// File: rtl/ifu.sv
// Instruction fetch unit: issues one fetch at a time to instruction memory,
// holds the returned word for decode, and advances pc sequentially or to a
// jump target at the consume handshake. Fetch faults and misaligned jump
// targets park the unit in a sticky FAULT state until reset.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_inc;
  logic        redirect_misaligned;

  // Sequential successor; 32-bit addition wraps modulo 2^32.
  assign pc_inc              = pc_q + 32'd4;
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  // Next-state and datapath update; responses only count in WAIT and
  // redirects only at the HOLD consume handshake.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            state_d = FAULT;
          end else begin
            inst_d  = imem_rsp_data;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (inst_ready) begin
          if (redirect_valid) begin
            if (redirect_misaligned) begin
              state_d = FAULT;
            end else begin
              pc_d    = redirect_pc;
              state_d = REQ;
            end
          end else begin
            pc_d    = pc_inc;
            state_d = REQ;
          end
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    fault          = 1'b0;
    unique case (state_q)
      REQ:     imem_req_valid = 1'b1;
      HOLD:    inst_valid     = 1'b1;
      FAULT:   fault          = 1'b1;
      default: ;
    endcase
  end

  assign imem_req_addr = pc_q;
  assign pc            = pc_q;
  assign inst          = inst_q;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: sequential fetch, backpressure, redirect, faults,
// pc wrap and reset in mid-transaction.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        req_valid, inst_valid, fault;
  logic [31:0] req_addr, inst, pc;

  logic        w_req_valid, w_inst_valid, w_fault;
  logic [31:0] w_req_addr, w_inst, w_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifu dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .pc(pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fault(fault)
  );

  ifu #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(w_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .inst_valid(w_inst_valid), .inst_ready(inst_ready),
    .inst(w_inst), .pc(w_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fault(w_fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One zero-wait fetch starting in REQ, ending back in REQ.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d);
    chk("req_valid_req", {31'd0, req_valid}, 32'd1);
    chk("req_addr", req_addr, a);
    chk("inst_valid_req", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("req_valid_wait", {31'd0, req_valid}, 32'd0);
    chk("inst_valid_wait", {31'd0, inst_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = d;
    tick();
    imem_rsp_valid = 1'b0;
    chk("inst_valid_hold", {31'd0, inst_valid}, 32'd1);
    chk("inst_hold", inst, d);
    chk("pc_hold", pc, a);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset state
    do_reset();
    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_inst", inst, 32'h0000_0013);
    tick();

    // Sequential fetch
    fetch(32'h8000_0000, 32'h1111_0001);
    fetch(32'h8000_0004, 32'h1111_0002);
    fetch(32'h8000_0008, 32'h1111_0003);

    // Request backpressure: address held, no duplicate request
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_req_valid", {31'd0, req_valid}, 32'd1);
      chk("bp_req_addr", req_addr, 32'h8000_000C);
      tick();
    end
    chk("bp_req_addr_last", req_addr, 32'h8000_000C);
    imem_req_ready = 1'b1;
    tick();
    chk("bp_no_dup", {31'd0, req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h2222_0004;
    inst_ready     = 1'b0;
    tick();
    imem_rsp_valid = 1'b0;
    // Decode backpressure: inst/pc held
    for (int i = 0; i < 5; i++) begin
      chk("ib_inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("ib_inst", inst, 32'h2222_0004);
      chk("ib_pc", pc, 32'h8000_000C);
      chk("ib_req_valid", {31'd0, req_valid}, 32'd0);
      tick();
    end
    inst_ready = 1'b1;
    tick();

    // Redirect at pc 8000_0010
    chk("rd_req_addr", req_addr, 32'h8000_0010);
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_006F;
    tick();
    imem_rsp_valid = 1'b0;
    chk("rd_pc", pc, 32'h8000_0010);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    chk("rd_target", req_addr, 32'h8000_0100);
    // Redirect pulsed in WAIT is ignored
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h3333_0001;
    tick();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    chk("rdw_pc", pc, 32'h8000_0100);
    tick();
    chk("rdw_seq", req_addr, 32'h8000_0104);

    // Misaligned redirect -> fault, pc unchanged
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h3333_0002;
    tick();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mis_fault", {31'd0, fault}, 32'd1);
      chk("mis_pc", pc, 32'h8000_0104);
      chk("mis_req_valid", {31'd0, req_valid}, 32'd0);
      chk("mis_inst_valid", {31'd0, inst_valid}, 32'd0);
      tick();
    end

    // Response error -> sticky fault, inst unchanged
    do_reset();
    chk("rst2_fault", {31'd0, fault}, 32'd0);
    tick();
    chk("err_req_addr", req_addr, 32'h8000_0000);
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_err   = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("err_fault", {31'd0, fault}, 32'd1);
      chk("err_inst", inst, 32'h0000_0013);
      chk("err_req_valid", {31'd0, req_valid}, 32'd0);
      tick();
    end

    // Wrap: RESET_PC = FFFF_FFFC
    do_reset();
    tick();
    chk("wrap_first", w_req_addr, 32'hFFFF_FFFC);
    fetch(32'h8000_0000, 32'h4444_0001);
    chk("wrap_second", w_req_addr, 32'h0000_0000);
    chk("wrap_req_valid", {31'd0, w_req_valid}, 32'd1);

    // Reset in WAIT, then stale response ignored
    tick();
    chk("rw_in_wait", {31'd0, req_valid}, 32'd0);
    do_reset();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    imem_req_ready = 1'b0;
    tick();
    tick();
    chk("stale_inst", inst, 32'h0000_0013);
    chk("stale_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("stale_req_addr", req_addr, 32'h8000_0000);
    chk("stale_w_req_addr", w_req_addr, 32'hFFFF_FFFC);
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    fetch(32'h8000_0000, 32'h5555_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
